debug_panel_scan: RTL and testbench



---
 rtl/debug_panel_scan.sv | 132 +++++++++++++
 tb/tb_debug_panel_scan.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_panel_scan.sv
// Front-panel driver: shows one of NCH debug channels (or the switches) on LED/SEG.
// Modes from the top two switch bits: direct, manual select, timed auto-scan, freeze.
module debug_panel_scan #(
   parameter int NBITS    = 8,
   parameter int NCH      = 32,
   parameter int SCAN_DIV = 4,
   localparam int SELW    = $clog2(NCH)
) (
   input  logic             clk_2,
   input  logic             reset_n,
   input  logic [NBITS-1:0] SWI,
   input  logic [NBITS-1:0] ch_data [0:NCH-1],
   output logic [NBITS-1:0] LED,
   output logic [7:0]       SEG,
   output logic [SELW-1:0]  lcd_sel,
   output logic             lcd_tick
);

   localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_MANUAL = 2'b01,
      MODE_AUTO   = 2'b10,
      MODE_FREEZE = 2'b11
   } mode_t;

   function automatic logic [6:0] hex7(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'h0: p = 7'h3F;
         4'h1: p = 7'h06;
         4'h2: p = 7'h5B;
         4'h3: p = 7'h4F;
         4'h4: p = 7'h66;
         4'h5: p = 7'h6D;
         4'h6: p = 7'h7D;
         4'h7: p = 7'h07;
         4'h8: p = 7'h7F;
         4'h9: p = 7'h6F;
         4'hA: p = 7'h77;
         4'hB: p = 7'h7C;
         4'hC: p = 7'h39;
         4'hD: p = 7'h5E;
         4'hE: p = 7'h79;
         4'hF: p = 7'h71;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   mode_t            mode_s;
   logic [SELW-1:0]  idx_s;
   logic [SELW-1:0]  sel_s, sel_r;
   logic [DIVW-1:0]  div_s, div_r;
   logic [NBITS-1:0] led_s, led_r;
   logic [7:0]       seg_s, seg_r;
   logic             tick_s, tick_r;

   // Next-state selection; outputs are computed from the new sel so they land in the same cycle.
   always_comb begin
      mode_s = mode_t'(SWI[NBITS-1:NBITS-2]);
      idx_s  = SWI[SELW-1:0];
      sel_s  = sel_r;
      div_s  = div_r;
      led_s  = led_r;
      seg_s  = seg_r;
      tick_s = 1'b0;
      case (mode_s)
         MODE_DIRECT: begin
            led_s = SWI;
            seg_s = {1'b0, hex7(SWI[3:0])};
            div_s = {DIVW{1'b0}};
         end
         MODE_MANUAL: begin
            if (idx_s > SELW'(NCH - 1)) begin
               sel_s = SELW'(NCH - 1);
            end else begin
               sel_s = idx_s;
            end
            div_s = {DIVW{1'b0}};
            led_s = ch_data[sel_s];
            seg_s = {1'b0, hex7(ch_data[sel_s][3:0])};
         end
         MODE_AUTO: begin
            if (div_r == DIVW'(SCAN_DIV - 1)) begin
               div_s  = {DIVW{1'b0}};
               tick_s = 1'b1;
               if (sel_r == SELW'(NCH - 1)) begin
                  sel_s = {SELW{1'b0}};
               end else begin
                  sel_s = sel_r + 1'b1;
               end
            end else begin
               div_s = div_r + 1'b1;
            end
            led_s = ch_data[sel_s];
            // dp marks the wrap back to channel 0
            seg_s = {(sel_s == {SELW{1'b0}}), hex7(ch_data[sel_s][3:0])};
         end
         MODE_FREEZE: begin
            tick_s = 1'b0;
         end
         default: begin
            tick_s = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         sel_r  <= {SELW{1'b0}};
         div_r  <= {DIVW{1'b0}};
         led_r  <= {NBITS{1'b0}};
         seg_r  <= 8'h00;
         tick_r <= 1'b0;
      end else begin
         sel_r  <= sel_s;
         div_r  <= div_s;
         led_r  <= led_s;
         seg_r  <= seg_s;
         tick_r <= tick_s;
      end
   end

   assign LED      = led_r;
   assign SEG      = seg_r;
   assign lcd_sel  = sel_r;
   assign lcd_tick = tick_r;

endmodule

// File: tb/tb_debug_panel_scan.sv
// Bench for debug_panel_scan: three configurations share clock, reset and switches,
// each compared every cycle against an arithmetic model plus directed literal checks.
module tb_debug_panel_scan;

   logic       clk_2 = 1'b0;
   logic       reset_n;
   logic [7:0] SWI;

   logic [7:0] cd_a [0:3];
   logic [7:0] cd_b [0:19];
   logic [7:0] cd_c [0:1];

   logic [7:0] led_a, led_b, led_c, seg_a, seg_b, seg_c;
   logic [1:0] sel_a;
   logic [4:0] sel_b;
   logic [0:0] sel_c;
   logic       tick_a, tick_b, tick_c;

   int total = 0;
   int bad   = 0;

   always #5 clk_2 = ~clk_2;

   debug_panel_scan #(.NBITS(8), .NCH(4), .SCAN_DIV(3)) u_a (
      .clk_2(clk_2), .reset_n(reset_n), .SWI(SWI), .ch_data(cd_a),
      .LED(led_a), .SEG(seg_a), .lcd_sel(sel_a), .lcd_tick(tick_a));
   debug_panel_scan #(.NBITS(8), .NCH(20), .SCAN_DIV(4)) u_b (
      .clk_2(clk_2), .reset_n(reset_n), .SWI(SWI), .ch_data(cd_b),
      .LED(led_b), .SEG(seg_b), .lcd_sel(sel_b), .lcd_tick(tick_b));
   debug_panel_scan #(.NBITS(8), .NCH(2), .SCAN_DIV(1)) u_c (
      .clk_2(clk_2), .reset_n(reset_n), .SWI(SWI), .ch_data(cd_c),
      .LED(led_c), .SEG(seg_c), .lcd_sel(sel_c), .lcd_tick(tick_c));

   logic [7:0] d_led [0:2];
   logic [7:0] d_seg [0:2];
   logic [7:0] d_sel [0:2];
   logic       d_tick [0:2];
   assign d_led[0] = led_a;  assign d_led[1] = led_b;  assign d_led[2] = led_c;
   assign d_seg[0] = seg_a;  assign d_seg[1] = seg_b;  assign d_seg[2] = seg_c;
   assign d_sel[0] = {6'd0, sel_a};
   assign d_sel[1] = {3'd0, sel_b};
   assign d_sel[2] = {7'd0, sel_c};
   assign d_tick[0] = tick_a; assign d_tick[1] = tick_b; assign d_tick[2] = tick_c;

   int nch_c [0:2] = '{4, 20, 2};
   int sd_c  [0:2] = '{3, 4, 1};
   int sw_c  [0:2] = '{2, 5, 1};
   logic [6:0] hex_t [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      int         sel;
      int         div;
      logic [7:0] led;
      logic [7:0] seg;
      logic       tick;
   } mst_t;

   mst_t ms [0:2];

   function automatic logic [7:0] chv(input int i, input int k);
      if (i == 0) return cd_a[k];
      else if (i == 1) return cd_b[k];
      else return cd_c[k];
   endfunction

   // One edge of the panel behaviour, written from the mode rules.
   function automatic mst_t step(input int i, input mst_t s, input logic [7:0] swi);
      mst_t n;
      int   idx;
      n = s;
      n.tick = 1'b0;
      case (swi[7:6])
         2'b00: begin
            n.led = swi;
            n.seg = {1'b0, hex_t[swi[3:0]]};
            n.div = 0;
         end
         2'b01: begin
            idx = int'(swi) % (1 << sw_c[i]);
            if (idx > nch_c[i] - 1) idx = nch_c[i] - 1;
            n.sel = idx;
            n.div = 0;
            n.led = chv(i, idx);
            n.seg = {1'b0, hex_t[n.led[3:0]]};
         end
         2'b10: begin
            if (s.div == sd_c[i] - 1) begin
               n.div  = 0;
               n.sel  = (s.sel + 1) % nch_c[i];
               n.tick = 1'b1;
            end else begin
               n.div = s.div + 1;
            end
            n.led = chv(i, n.sel);
            n.seg = {(n.sel == 0), hex_t[n.led[3:0]]};
         end
         default: n.tick = 1'b0;
      endcase
      return n;
   endfunction

   always @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) ms[i] <= '{sel: 0, div: 0, led: 8'h00, seg: 8'h00, tick: 1'b0};
      end else begin
         for (int i = 0; i < 3; i++) ms[i] <= step(i, ms[i], SWI);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_ch(input int off);
      for (int k = 0; k < 4; k++)  cd_a[k] = 8'(k * 17 + off);
      for (int k = 0; k < 20; k++) cd_b[k] = 8'(k * 17 + off);
      for (int k = 0; k < 2; k++)  cd_c[k] = 8'(k * 17 + off);
   endtask

   // Model comparison on every falling edge.
   initial forever begin
      @(negedge clk_2);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("model_led%0d", i), int'(d_led[i]), int'(ms[i].led));
         chk($sformatf("model_seg%0d", i), int'(d_seg[i]), int'(ms[i].seg));
         chk($sformatf("model_sel%0d", i), int'(d_sel[i]), ms[i].sel);
         chk($sformatf("model_tick%0d", i), int'(d_tick[i]), int'(ms[i].tick));
      end
   end

   initial begin
      SWI = 8'hA7;
      set_ch(0);
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk_2);
      chk("rst_led", led_a, 8'h00);
      chk("rst_seg", seg_a, 8'h00);
      chk("rst_sel", sel_a, 0);
      chk("rst_tick", tick_a, 0);

      SWI = 8'h05; reset_n = 1'b1;
      @(negedge clk_2);
      chk("direct_led", led_a, 8'h05);
      chk("direct_seg", seg_a, 8'h6D);

      SWI = 8'h3A;
      @(negedge clk_2);
      chk("direct2_led", led_a, 8'h3A);
      chk("direct2_seg", seg_a, 8'h77);

      SWI = 8'h43;
      @(negedge clk_2);
      chk("manual_sel", sel_a, 3);
      chk("manual_led", led_a, 8'h33);
      chk("manual_seg", seg_a, 8'h4F);

      SWI = 8'h5F;
      @(negedge clk_2);
      chk("clamp_sel", sel_b, 19);
      chk("clamp_led", led_b, 8'h43);
      chk("clamp_sel_a", sel_a, 3);

      SWI = 8'h40;
      @(negedge clk_2);
      chk("manual0_sel", sel_a, 0);

      SWI = 8'h80;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk_2);
         chk("auto_sel_a", sel_a, (c / 3) % 4);
         chk("auto_tick_a", tick_a, (c % 3 == 0) ? 1 : 0);
         chk("auto_sel_b", sel_b, c / 4);
         chk("div1_sel_c", sel_c, c % 2);
         chk("div1_tick_c", tick_c, 1);
      end
      chk("wrap_seg", seg_a, 8'hBF);

      repeat (7) @(negedge clk_2);
      chk("prefreeze_sel", sel_a, 2);

      SWI = 8'hC0;
      set_ch(5);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_2);
         chk("freeze_sel", sel_a, 2);
         chk("freeze_led", led_a, 8'h22);
         chk("freeze_seg", seg_a, 8'h5B);
         chk("freeze_tick", tick_a, 0);
      end

      SWI = 8'h80;
      @(negedge clk_2);
      chk("resume1_sel", sel_a, 2);
      chk("resume1_tick", tick_a, 0);
      chk("resume1_led", led_a, 8'h27);
      chk("resume1_seg", seg_a, 8'h07);
      @(negedge clk_2);
      chk("resume2_sel", sel_a, 3);
      chk("resume2_tick", tick_a, 1);
      chk("resume2_led", led_a, 8'h38);
      chk("resume2_seg", seg_a, 8'h7F);

      #2 reset_n = 1'b0;
      #1;
      chk("async_led", led_a, 8'h00);
      chk("async_seg", seg_a, 8'h00);
      chk("async_sel", sel_a, 0);
      chk("async_tick", tick_a, 0);
      #1 reset_n = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk_2);
         chk("restart_sel", sel_a, (c == 3) ? 1 : 0);
         chk("restart_tick", tick_a, (c == 3) ? 1 : 0);
      end

      SWI = 8'hC0;
      repeat (3) @(negedge clk_2);
      chk("final_freeze_tick_c", tick_c, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
